// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: arbiter FSM encoding, requester port ids and
// controller timing constants.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // Controller timing, in core clocks
    localparam int SDRAM_CAS_LATENCY    = 2;
    localparam int SDRAM_T_RCD          = 2;
    localparam int SDRAM_T_RP           = 2;
    localparam int SDRAM_REFRESH_CYCLES = 780;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of an SDRAM controller.
// Request sampled in IDLE reaches c_*_req next cycle; ack one cycle after c_busy falls.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_req,
    output logic [DATA_W-1:0] i_data,
    output logic              i_ack,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_read_req,
    input  logic              d_write_req,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    input  logic [DATA_W-1:0] c_data_out,
    output logic              c_read_req,
    output logic              c_write_req,
    input  logic              c_busy
);

    arb_state_e        state_q, state_d;
    port_e             grant_q, grant_d;
    port_e             last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;

    logic              d_pending;
    logic              pick_data;
    logic              pick_write;

    // Data wins when it is alone, or on a tie when fetch was served last
    assign d_pending  = d_read_req | d_write_req;
    assign pick_data  = d_pending & (~i_req | (last_grant_q == PORT_FETCH));
    assign pick_write = pick_data & d_write_req;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_data_d     = i_data_q;
        d_rdata_d    = d_rdata_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!c_busy && (i_req || d_pending)) begin
                    grant_d      = pick_data ? PORT_DATA : PORT_FETCH;
                    last_grant_d = pick_data ? PORT_DATA : PORT_FETCH;
                    wr_d         = pick_write;
                    addr_d       = pick_data ? d_addr : i_addr;
                    wdata_d      = d_wdata;
                    rd_req_d     = ~pick_write;
                    wr_req_d     = pick_write;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (c_busy) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!c_busy) begin
                    if (!wr_q) begin
                        if (grant_q == PORT_DATA) begin
                            d_rdata_d = c_data_out;
                        end else begin
                            i_data_d = c_data_out;
                        end
                    end
                    i_ack_d = (grant_q == PORT_FETCH);
                    d_ack_d = (grant_q == PORT_DATA);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset abandons any open transaction; IDLE then waits for c_busy to clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_data_q     <= i_data_d;
            d_rdata_q    <= d_rdata_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign i_data      = i_data_q;
    assign i_ack       = i_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_ack       = d_ack_q;
    assign c_addr      = addr_q;
    assign c_data_in   = wdata_q;
    assign c_read_req  = rd_req_q;
    assign c_write_req = wr_req_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench: requester and controller models drive the arbiter, a
// transaction-level scoreboard predicts every output each cycle.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] i_addr = '0;
    logic        i_req = 1'b0;
    logic [15:0] i_data;
    logic        i_ack;
    logic [23:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_read_req = 1'b0;
    logic        d_write_req = 1'b0;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic [23:0] c_addr;
    logic [15:0] c_data_in;
    logic [15:0] c_data_out = '0;
    logic        c_read_req;
    logic        c_write_req;
    logic        c_busy = 1'b0;

    sdram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_ack      (i_ack),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_read_req (d_read_req),
        .d_write_req(d_write_req),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .c_addr     (c_addr),
        .c_data_in  (c_data_in),
        .c_data_out (c_data_out),
        .c_read_req (c_read_req),
        .c_write_req(c_write_req),
        .c_busy     (c_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef enum int {PH_FREE, PH_REQ, PH_ACC, PH_DONE} ph_e;
    typedef struct packed {
        logic [23:0] a;
        logic [15:0] w;
        logic        rd;
        logic        wr;
    } dreq_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] mem [logic [23:0]];

    // Scoreboard state
    ph_e         ph = PH_FREE;
    bit          last_data = 1'b1;
    bit          g_data, g_wr;
    logic [23:0] g_addr;
    logic [15:0] g_wdata;
    logic [15:0] exp_i = '0;
    logic [15:0] exp_d = '0;
    int          glog[$];
    int          n_fdone = 0;
    int          n_ddone = 0;
    int          rd_hi = 0;

    // Requester / controller model state
    logic [23:0] fq[$];
    dreq_t       dq[$];
    bit          f_act = 0, f_cool = 0, d_act = 0, d_cool = 0;
    bit          rand_en = 0;
    int          ctl_busy_left = 0, ctl_seen = 0, ctl_need = 1;
    int          fixed_dly = 0, fixed_busy = 0;
    bit          ctl_wr;
    logic [23:0] ctl_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd_mem(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [23:0] rnd_addr();
        logic [23:0] r;
        r = 24'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) r[22] = 1'b1;
        return r;
    endfunction

    // Compare DUT outputs against what the transaction rules predict, given
    // the inputs that were applied during the cycle just ended.
    task automatic check_cycle();
        bit e_rd, e_wr, e_ia, e_da;
        if (c_read_req) rd_hi++;
        if (rst) begin
            ph = PH_FREE; last_data = 1'b1; exp_i = '0; exp_d = '0;
            chk("rst_c_read_req", c_read_req, 0);
            chk("rst_c_write_req", c_write_req, 0);
            chk("rst_i_ack", i_ack, 0);
            chk("rst_d_ack", d_ack, 0);
            chk("rst_c_addr", c_addr, 0);
            chk("rst_c_data_in", c_data_in, 0);
            chk("rst_i_data", i_data, 0);
            chk("rst_d_rdata", d_rdata, 0);
            return;
        end
        case (ph)
            PH_FREE: begin
                if (!c_busy && (i_req || d_read_req || d_write_req)) begin
                    g_data    = (d_read_req || d_write_req) && (!i_req || !last_data);
                    last_data = g_data;
                    g_wr      = g_data && d_write_req;
                    g_addr    = g_data ? d_addr : i_addr;
                    g_wdata   = d_wdata;
                    glog.push_back(int'(g_data));
                    ph = PH_REQ;
                end
            end
            PH_REQ:  if (c_busy) ph = PH_ACC;
            PH_ACC: begin
                if (!c_busy) begin
                    ph = PH_DONE;
                    if (!g_wr) begin
                        if (g_data) exp_d = rd_mem(g_addr);
                        else        exp_i = rd_mem(g_addr);
                    end
                    if (g_data) n_ddone++;
                    else        n_fdone++;
                end
            end
            default: ph = PH_FREE;
        endcase
        e_rd = (ph == PH_REQ) && !g_wr;
        e_wr = (ph == PH_REQ) && g_wr;
        e_ia = (ph == PH_DONE) && !g_data;
        e_da = (ph == PH_DONE) && g_data;
        chk("c_read_req", c_read_req, e_rd);
        chk("c_write_req", c_write_req, e_wr);
        chk("i_ack", i_ack, e_ia);
        chk("d_ack", d_ack, e_da);
        chk("i_data", i_data, exp_i);
        chk("d_rdata", d_rdata, exp_d);
        if (ph == PH_REQ) chk("c_addr", c_addr, g_addr);
        if (ph == PH_REQ && g_wr) chk("c_data_in", c_data_in, g_wdata);
    endtask

    task automatic drive_next();
        dreq_t r;
        c_data_out = 16'($urandom);
        if (ctl_busy_left > 0) begin
            ctl_busy_left--;
            if (ctl_busy_left == 0) begin
                c_busy = 1'b0;
                if (!ctl_wr) c_data_out = rd_mem(ctl_addr);
            end
        end else if (c_read_req || c_write_req) begin
            if (ctl_seen == 0) ctl_need = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
            ctl_seen++;
            if (ctl_seen >= ctl_need) begin
                c_busy   = 1'b1;
                ctl_wr   = c_write_req;
                ctl_addr = c_addr;
                if (c_write_req) mem[c_addr] = c_data_in;
                ctl_busy_left = (fixed_busy > 0) ? fixed_busy : int'($urandom_range(1, 4));
                ctl_seen = 0;
            end
        end

        if (f_act) begin
            if (i_ack) begin
                f_act = 0; i_req = 1'b0; f_cool = 1;
            end else if ((ph == PH_REQ || ph == PH_ACC) && !g_data) begin
                i_addr = rnd_addr();
            end
        end else if (f_cool) begin
            f_cool = 0;
        end else if (fq.size() > 0) begin
            i_addr = fq.pop_front(); i_req = 1'b1; f_act = 1;
        end else if (rand_en && $urandom_range(0, 99) < 40) begin
            i_addr = rnd_addr(); i_req = 1'b1; f_act = 1;
        end

        if (d_act) begin
            if (d_ack) begin
                d_act = 0; d_read_req = 1'b0; d_write_req = 1'b0; d_cool = 1;
            end else if ((ph == PH_REQ || ph == PH_ACC) && g_data) begin
                d_addr = rnd_addr(); d_wdata = 16'($urandom);
            end
        end else if (d_cool) begin
            d_cool = 0;
        end else if (dq.size() > 0 || (rand_en && $urandom_range(0, 99) < 40)) begin
            if (dq.size() > 0) begin
                r = dq.pop_front();
            end else begin
                r.a = rnd_addr(); r.w = 16'($urandom);
                case ($urandom_range(0, 2))
                    0:       begin r.rd = 1'b1; r.wr = 1'b0; end
                    1:       begin r.rd = 1'b0; r.wr = 1'b1; end
                    default: begin r.rd = 1'b1; r.wr = 1'b1; end
                endcase
            end
            d_addr = r.a; d_wdata = r.w; d_read_req = r.rd; d_write_req = r.wr; d_act = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_cycle();
        drive_next();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (fq.size() == 0 && dq.size() == 0 && !f_act && !d_act && ph == PH_FREE
                && ctl_busy_left == 0) break;
            step();
        end
        chk(tag, 32'(k < budget), 1);
    endtask

    initial begin
        int k, n0;
        mem[24'h000123] = 16'hBEEF;

        repeat (3) step();
        rst = 1'b0;

        // Both ports held after reset: fetch, data, fetch, data
        glog.delete();
        fq.push_back(24'h000200);
        fq.push_back(24'h000201);
        dq.push_back('{24'h400200, 16'h0000, 1'b1, 1'b0});
        dq.push_back('{24'h400201, 16'h0000, 1'b1, 1'b0});
        run_until_idle("rr_done", 200);
        chk("rr_count", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("rr_order", glog[i], i % 2);

        fq.push_back(24'h000123);
        run_until_idle("fetch_done", 100);
        chk("fetch_beef", i_data, 16'hBEEF);

        dq.push_back('{24'h400010, 16'h1234, 1'b0, 1'b1});
        run_until_idle("write_done", 100);
        chk("write_mem", mem[24'h400010], 16'h1234);

        fixed_dly = 5;
        rd_hi = 0;
        fq.push_back(24'h000042);
        run_until_idle("delay_done", 100);
        chk("delay_req_cycles", rd_hi, 5);
        fixed_dly = 0;

        rd_hi = 0;
        dq.push_back('{24'h000077, 16'hCAFE, 1'b1, 1'b1});
        run_until_idle("rdwr_done", 100);
        chk("rdwr_no_read", rd_hi, 0);
        chk("rdwr_mem", mem[24'h000077], 16'hCAFE);

        rand_en = 1;
        repeat (1500) step();
        rand_en = 0;
        run_until_idle("random_drain", 200);

        // Reset while the controller is busy with a data read
        fixed_busy = 8;
        dq.push_back('{24'h000055, 16'h0000, 1'b1, 1'b0});
        for (k = 0; k < 100; k++) begin
            if (ph == PH_ACC && c_busy) break;
            step();
        end
        chk("rst_reach_wait", 32'(k < 100), 1);
        #3;
        rst = 1'b1;
        ctl_busy_left = 6;
        ctl_seen = 0;
        #1;
        chk("arst_c_read_req", c_read_req, 0);
        chk("arst_c_write_req", c_write_req, 0);
        chk("arst_i_ack", i_ack, 0);
        chk("arst_d_ack", d_ack, 0);
        chk("arst_c_addr", c_addr, 0);
        chk("arst_c_data_in", c_data_in, 0);
        chk("arst_i_data", i_data, 0);
        chk("arst_d_rdata", d_rdata, 0);
        ph = PH_FREE; last_data = 1'b1; exp_i = '0; exp_d = '0;
        step();
        rst = 1'b0;
        fixed_busy = 0;
        n0 = n_ddone;
        run_until_idle("rst_recover", 100);
        chk("rst_reissue_done", n_ddone - n0, 1);

        rand_en = 1;
        repeat (300) step();
        rand_en = 0;
        run_until_idle("final_drain", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, requester/SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_addr  input  ADDR_W  instruction-fetch read address.
REQ-006 SHALL have port i_req  input  1  fetch read request, level, held until i_ack.
REQ-007 SHALL have port i_data  output  DATA_W  fetch read data, valid in i_ack cycle.
REQ-008 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_addr  input  ADDR_W  data-port address.
REQ-010 SHALL have port d_wdata  input  DATA_W  data-port write data.
REQ-011 SHALL have port d_read_req  input  1  data read request, level, held until d_ack.
REQ-012 SHALL have port d_write_req  input  1  data write request, level, held until d_ack.
REQ-013 SHALL have port d_rdata  output  DATA_W  data-port read data, valid in d_ack cycle.
REQ-014 SHALL have port d_ack  output  1  one-cycle data-port completion pulse.
REQ-015 SHALL have port c_addr  output  ADDR_W  address to SDRAM controller.
REQ-016 SHALL have port c_data_in  output  DATA_W  write data to SDRAM controller.
REQ-017 SHALL have port c_data_out  input  DATA_W  read data from SDRAM controller.
REQ-018 SHALL have ports c_read_req, c_write_req  output  1 each  controller requests.
REQ-019 SHALL have port c_busy  input  1  controller busy; high from acceptance until done.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-021 IDLE: grant only when c_busy=0 and a request is pending; latch port, op, addr, wdata; next ISSUE.
REQ-022 Arbitration: single requester wins; both pending -> port not granted last (round-robin via last_grant bit).
REQ-023 d_read_req and d_write_req both high SHALL be treated as write.
REQ-024 ISSUE: hold c_read_req or c_write_req high with latched c_addr/c_data_in until c_busy=1 sampled; then drop request, go WAIT.
REQ-025 WAIT: on c_busy=0, reads latch c_data_out into granted port's data register; go RESP.
REQ-026 RESP: granted port's ack high exactly one cycle; next IDLE; ack never high for both ports.
REQ-027 Requester SHALL drop its req in cycle after ack; IDLE re-samples reqs then (back-to-back allowed, one transaction per grant).
REQ-028 Request/address/data changes during ISSUE/WAIT/RESP SHALL be ignored (latched values used).
REQ-029 i_data/d_rdata SHALL hold last read value until that port's next read completion; writes leave d_rdata unchanged.
REQ-030 Minimum turnaround: request sampled in IDLE at cycle N -> c_*_req high at N+1.
REQ-031 c_read_req and c_write_req SHALL never be high simultaneously.

Reset
REQ-032 On rst: state IDLE, c_read_req=c_write_req=0, i_ack=d_ack=0, c_addr=c_data_in=i_data=d_rdata=0, last_grant=data (fetch wins first tie).
REQ-033 Reset mid-transaction abandons it without ack; after release no new issue until c_busy=0.

Structure
REQ-034 FSM state encoding and port-id constants SHALL live in shared package sdram_pkg with the SDRAM controller's constants.
REQ-035 Single flat module; no sub-module required.

Verification
REQ-036 Fetch read 0x000123, controller returns 0xBEEF -> c_read_req high until c_busy, i_ack one cycle, i_data=0xBEEF.
REQ-037 Data write 0x400010/0x1234 -> c_write_req, c_addr=0x400010, c_data_in=0x1234, d_ack one cycle, d_rdata unchanged.
REQ-038 i_req and d_read_req both high after reset, held -> grants fetch, data, fetch, data alternately.
REQ-039 Controller delays c_busy 5 cycles -> c_read_req stays high 5 cycles, addr stable, no ack early.
REQ-040 rst asserted during WAIT with c_busy=1 -> all outputs 0 immediately; no issue until c_busy falls.
REQ-041 d_read_req and d_write_req both high -> write issued, c_read_req never high.
